// File: rtl/control.sv
// control: front-panel controller for the guitar-pedal effect chain.
// It turns slide switches and push buttons into effect enables and per-effect
// option words, and drives the status LEDs. It runs on the 12 Hz UI clock.
// Optional feature macro: CONTROL_BLINK_EN. When it is defined, the EDIT-mode
// cursor LED blinks. When it is undefined, that LED is steady and the blink
// counter is not built.
module control #(
    parameter int HOLD_CYCLES = 8,
    parameter int BLINK_DIV   = 8
) (
    input  logic       clk_12hz,
    input  logic       rst_n,
    input  logic [7:0] switches,
    input  logic [2:0] butn_in,
    output logic [7:0] leds,
    output logic [3:0] en,
    output logic [3:0] options0,
    output logic [3:0] options1,
    output logic [3:0] options2,
    output logic [3:0] options3
);

    typedef enum logic {PLAY, EDIT} mode_t;

    localparam int              HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLD_CYCLES);

    logic [7:0] switches_s1, switches_s2;
    logic [2:0] butn_in_s1, butn_in_s2;
    logic [1:0] butn_prev;            // {left, right} as seen one cycle earlier
    logic       right_edge, left_edge;
    logic [1:0] cursor;
    mode_t      mode;
    logic [HW-1:0] hold_cnt;
    logic       armed;
    logic [3:0] opt [4];
    logic [3:0] cursor_onehot;
    logic       blink_on;

    // Two-flop synchronizers for the asynchronous board inputs, plus the
    // previous-cycle copy of the right/left buttons for edge detection.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others; blocking here would collapse the chain.
    always_ff @(posedge clk_12hz or negedge rst_n) begin
        if (!rst_n) begin
            switches_s1 <= '0;
            switches_s2 <= '0;
            butn_in_s1  <= '0;
            butn_in_s2  <= '0;
            butn_prev   <= '0;
        end else begin
            switches_s1 <= switches;
            switches_s2 <= switches_s1;
            butn_in_s1  <= butn_in;
            butn_in_s2  <= butn_in_s1;
            butn_prev   <= {butn_in_s2[2], butn_in_s2[0]};
        end
    end

    assign right_edge    = butn_in_s2[0] & ~butn_prev[0];
    assign left_edge     = butn_in_s2[2] & ~butn_prev[1];
    assign cursor_onehot = 4'b0001 << cursor;

    // Cursor steps once per button press; simultaneous right+left cancel.
    always_ff @(posedge clk_12hz or negedge rst_n) begin
        if (!rst_n) begin
            cursor <= 2'd0;
        end else if (right_edge && !left_edge) begin
            cursor <= cursor + 2'd1;
        end else if (left_edge && !right_edge) begin
            cursor <= cursor - 2'd1;
        end
    end

    // Mode FSM: a long centre press toggles PLAY/EDIT exactly once per press.
    always_ff @(posedge clk_12hz or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= PLAY;
            hold_cnt <= '0;
            armed    <= 1'b0;
        end else if (butn_in_s2[1]) begin
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (hold_cnt == HOLD_LAST && !armed) begin
                mode  <= (mode == PLAY) ? EDIT : PLAY;
                armed <= 1'b1;
            end
        end else begin
            hold_cnt <= '0;
            armed    <= 1'b0;
        end
    end

    // Effect enables follow the switches; in EDIT the selected option word
    // follows the upper switches, using the pre-edge mode and cursor.
    // NOTE: the option words are four small registers, not a RAM, so they
    // take the async reset like any other flop.
    always_ff @(posedge clk_12hz or negedge rst_n) begin
        if (!rst_n) begin
            en <= '0;
            for (int i = 0; i < 4; i++) begin
                opt[i] <= '0;
            end
        end else begin
            en <= switches_s2[3:0];
            if (mode == EDIT) begin
                opt[cursor] <= switches_s2[7:4];
            end
        end
    end

    assign options0 = opt[0];
    assign options1 = opt[1];
    assign options2 = opt[2];
    assign options3 = opt[3];

`ifdef CONTROL_BLINK_EN
    localparam int            BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_DIV / 2);

    logic [BW-1:0] blink_cnt;

    // Free-running blink divider; the LED is lit during the first half.
    always_ff @(posedge clk_12hz or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_on = (blink_cnt < BLINK_HALF);
`else
    assign blink_on = 1'b1;
`endif

    // Status LEDs show the enables in PLAY, and the selected option word plus
    // the cursor position in EDIT; they trail the state by one edge.
    always_ff @(posedge clk_12hz or negedge rst_n) begin
        if (!rst_n) begin
            leds <= '0;
        end else if (mode == PLAY) begin
            leds <= {4'b0000, en};
        end else begin
            leds <= {opt[cursor], blink_on ? cursor_onehot : 4'b0000};
        end
    end

endmodule

// File: tb/tb_control.sv
// tb_control: directed bench for control with a behavioural reference model
// that is checked against the DUT outputs on every clock cycle.
module tb_control;

    localparam int HOLD = 8;
    localparam int DIV  = 8;
`ifdef CONTROL_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk_12hz = 1'b0;
    logic       rst_n;
    logic [7:0] switches;
    logic [2:0] butn_in;
    logic [7:0] leds;
    logic [3:0] en, options0, options1, options2, options3;

    int tests = 0;
    int fails = 0;

    control #(.HOLD_CYCLES(HOLD), .BLINK_DIV(DIV)) dut (
        .clk_12hz (clk_12hz),
        .rst_n    (rst_n),
        .switches (switches),
        .butn_in  (butn_in),
        .leds     (leds),
        .en       (en),
        .options0 (options0),
        .options1 (options1),
        .options2 (options2),
        .options3 (options3)
    );

    always #5 clk_12hz = ~clk_12hz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs seen by the control logic are the board inputs delayed by two
    // clock edges; the model keeps a short history of what the bench drove.
    logic [7:0] h1_sw, h2_sw, h3_sw;
    logic [2:0] h1_b, h2_b, h3_b;
    logic [3:0] m_en;
    logic [3:0] m_opt [4];
    int         m_cursor;
    bit         m_edit;
    int         m_run;
    int         m_edges;
    logic [7:0] m_leds;

    always @(posedge clk_12hz or negedge rst_n) begin
        if (!rst_n) begin
            h1_sw = '0; h2_sw = '0; h3_sw = '0;
            h1_b = '0;  h2_b = '0;  h3_b = '0;
            m_en = '0;
            for (int i = 0; i < 4; i++) m_opt[i] = '0;
            m_cursor = 0; m_edit = 0; m_run = 0; m_edges = 0;
            m_leds = '0;
        end else begin
            logic r, l;
            logic [3:0] pos;
            // LEDs show the state as it stood before this edge
            pos = 4'b0001 << m_cursor;
            if (!m_edit)
                m_leds = {4'b0000, m_en};
            else if (!BLINK || ((m_edges % DIV) < DIV / 2))
                m_leds = {m_opt[m_cursor], pos};
            else
                m_leds = {m_opt[m_cursor], 4'b0000};
            m_en = h2_sw[3:0];
            if (m_edit) m_opt[m_cursor] = h2_sw[7:4];
            r = h2_b[0] && !h3_b[0];
            l = h2_b[2] && !h3_b[2];
            if (r && !l) m_cursor = (m_cursor + 1) % 4;
            else if (l && !r) m_cursor = (m_cursor + 3) % 4;
            m_run = h2_b[1] ? m_run + 1 : 0;
            if (m_run == HOLD) m_edit = !m_edit;
            m_edges++;
            h3_sw = h2_sw; h2_sw = h1_sw; h1_sw = switches;
            h3_b = h2_b;   h2_b = h1_b;   h1_b = butn_in;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_12hz) begin
        check("leds", leds, m_leds);
        check("en", en, m_en);
        check("options0", options0, m_opt[0]);
        check("options1", options1, m_opt[1]);
        check("options2", options2, m_opt[2]);
        check("options3", options3, m_opt[3]);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_12hz);
    endtask

    task automatic pulse(input logic [2:0] b);
        butn_in = b;
        cyc(2);
        butn_in = 3'b000;
        cyc(4);
    endtask

    initial begin
        int on_cnt, off_cnt;
        rst_n = 1'b0;
        switches = '0;
        butn_in = '0;
        cyc(3);
        rst_n = 1'b1;

        // reset state with idle inputs
        cyc(10);
        check("rst_en", en, 4'h0);
        check("rst_opts", {options3, options2, options1, options0}, 16'h0000);
        check("rst_leds", leds, 8'h00);

        // enables in PLAY, latency 3, LEDs one edge later
        switches = 8'h0F;
        cyc(2);
        check("en_edge2", en, 4'h0);
        cyc(1);
        check("en_edge3", en, 4'hF);
        check("leds_edge3", leds, 8'h00);
        cyc(1);
        check("leds_play", leds, 8'h0F);
        check("opts_play", {options3, options2, options1, options0}, 16'h0000);

        // cursor moves (model pinned by hand values)
        pulse(3'b001);
        check("cursor_right", m_cursor, 1);
        pulse(3'b100);
        check("cursor_left", m_cursor, 0);
        pulse(3'b100);
        check("cursor_wrap", m_cursor, 3);
        pulse(3'b101);
        check("cursor_both", m_cursor, 3);
        butn_in = 3'b001;
        cyc(20);
        butn_in = 3'b000;
        cyc(4);
        check("cursor_long", m_cursor, 0);

        // short centre press: no toggle
        butn_in = 3'b010;
        cyc(5);
        butn_in = 3'b000;
        cyc(8);
        check("short_hold", leds, 8'h0F);

        // long centre press: one toggle on edge 10, visible on edge 11
        butn_in = 3'b010;
        cyc(10);
        check("hold_edge10", leds, 8'h0F);
        check("model_edit", m_edit, 1);
        cyc(1);
        check("hold_edge11", leds & 8'hFE, 8'h00);
        cyc(5);
        butn_in = 3'b000;
        cyc(25);
        check("one_toggle", leds & 8'hFE, 8'h00);

        // EDIT with cursor 0
        switches = 8'hF0;
        cyc(3);
        check("edit_opt0", options0, 4'hF);
        check("edit_en", en, 4'h0);
        check("edit_others", {options3, options2, options1}, 12'h000);
        cyc(1);
        check("edit_leds_hi", leds[7:4], 4'hF);

        // cursor to 2, then observe the cursor LED
        switches = 8'h00;
        pulse(3'b001);
        pulse(3'b001);
        cyc(4);
        on_cnt = 0;
        off_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (leds[3:0] == 4'b0100) on_cnt++;
            else if (leds[3:0] == 4'b0000) off_cnt++;
            cyc(1);
        end
        check("blink_on_cnt", on_cnt, BLINK ? 8 : 16);
        check("blink_off_cnt", off_cnt, BLINK ? 8 : 0);

        // toggle and write on the same edge: write uses the EDIT mode
        switches = 8'h30;
        cyc(4);
        check("pre_toggle_opt2", options2, 4'h3);
        butn_in = 3'b010;
        cyc(7);
        switches = 8'hC5;
        cyc(3);
        check("toggle_write_opt2", options2, 4'hC);
        check("toggle_write_en", en, 4'h5);
        cyc(1);
        check("back_to_play", leds, 8'h05);
        butn_in = 3'b000;
        cyc(6);

        // back to EDIT, then cursor move and write on the same edge
        butn_in = 3'b010;
        cyc(12);
        butn_in = 3'b000;
        switches = 8'h90;
        cyc(6);
        check("opt2_nine", options2, 4'h9);
        switches = 8'h60;
        butn_in = 3'b001;
        cyc(1);
        switches = 8'h10;
        cyc(2);
        check("move_write_opt2", options2, 4'h6);
        check("move_write_opt3", options3, 4'h0);
        cyc(1);
        check("after_move_opt3", options3, 4'h1);
        butn_in = 3'b000;
        cyc(4);

        // reset in the middle of a hold clears everything at once
        switches = 8'h00;
        butn_in = 3'b010;
        cyc(5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_leds", leds, 8'h00);
        check("mid_rst_opts", {options3, options2, options1, options0, en}, 20'h00000);
        butn_in = 3'b000;
        cyc(2);
        rst_n = 1'b1;
        cyc(12);
        check("post_rst_leds", leds, 8'h00);
        check("post_rst_opts", {options3, options2, options1, options0}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control.md
# control

Front-panel controller for the guitar-pedal effect chain. It turns eight slide switches and three push buttons into four effect-enable bits and four 4-bit option words, and drives eight status LEDs. It runs on the slow 12 Hz UI clock and sits between the board I/O and the effect datapath, whose `en`/`options*` inputs it feeds.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- `HOLD_CYCLES`, default 8: consecutive cycles the centre button must be held to toggle mode (one 1.5 Hz period).
- `BLINK_DIV`, default 8: blink period in clock cycles (12 Hz / 8 = 1.5 Hz).

Ports:
- `clk_12hz`  in  1  UI clock; all state updates on its rising edge.
- `rst_n`  in  1  async active-low reset.
- `switches`  in  8  slide switches, asynchronous to the clock.
  - [3:0] effect enables.
  - [7:4] option value.
- `butn_in`  in  3  push buttons, asynchronous to the clock; [0] right, [1] centre, [2] left.
- `leds`  out  8  status LEDs, registered.
- `en`  out  4  effect enables, registered.
- `options0`..`options3`  out  4 each  per-effect option words, registered.

## Operation
- Input conditioning:
  - `switches` and `butn_in` each pass through a 2-flop synchronizer (`*_s2`).
  - Right and left buttons then go through a rising-edge detector (`s2 & ~prev`).
- `en` is loaded from `switches_s2[3:0]` every cycle, in both modes.
- `cursor` is 2 bits, reset 0. It selects an effect 0..3.
  - Right edge: `cursor+1` mod 4; 3 wraps to 0.
  - Left edge: `cursor-1` mod 4; 0 wraps to 3.
  - Right and left edges in the same cycle: no move.
  - Cursor moves in both modes.
- Mode FSM, two states:
  - PLAY (reset state) and EDIT.
  - Hold counter counts consecutive cycles with `butn_in_s2[1]=1`. It saturates and clears when the button is released.
  - Mode toggles (PLAY↔EDIT) in the cycle the count reaches `HOLD_CYCLES`.
  - After a toggle, an armed flag blocks further toggles until the centre button is released. One toggle per press, however long it is held.
  - A press shorter than `HOLD_CYCLES` has no effect.
- Options:
  - In EDIT, `options[cursor] <= switches_s2[7:4]` every cycle.
  - The other three option words hold.
  - In PLAY, all options hold.
- LEDs:
  - PLAY: `leds = {4'b0000, en}`.
  - EDIT: `leds[7:4] = options[cursor]`; `leds[3:0]` = one-hot of `cursor`, gated by blink phase.
- Blink counter: free-running mod `BLINK_DIV`, reset 0. Phase = 1 while the counter is below `BLINK_DIV/2`.

## Timing
- Reset values: `leds=0`, `en=0`, `options0..3=0`, `cursor=0`, mode=PLAY, hold counter=0, blink counter=0.
- Reset asserted mid-operation clears everything immediately, including any in-progress hold or edit.
- Latency, counted from the first rising edge that samples the new input:
  - `en` and `options` update on edge 3.
  - Cursor moves on edge 3.
  - Mode toggles on edge 2+`HOLD_CYCLES` (= edge 10 for the default).
  - `leds` reflect new state one edge later than that state changes.
- A button held for many cycles produces exactly one cursor step.
- A mode toggle and an options write in the same cycle:
  - The write uses the pre-toggle mode.
  - A cursor move and an options write in the same cycle use the pre-move cursor.

## Configuration
- `CONTROL_BLINK_EN` defined: the EDIT-mode cursor LED blinks at 1.5 Hz, 4 cycles on, 4 cycles off.
- Undefined: the cursor LED is steady on and the blink counter is not built.

## Test plan
- Reset, all inputs 0, run 10 cycles -> `en=0000`, `options0..3=0`, `leds=00000000`.
- `switches=00001111` in PLAY -> `en=1111` by edge 3; `leds=00001111`; options unchanged.
- Pulse right for 2 cycles -> cursor 0→1. Pulse left -> back to 0. Left again from 0 -> 3 (wrap). Right and left together -> no move.
- Hold centre for 16 cycles -> exactly one toggle to EDIT (on edge 10). Hold centre for 5 cycles only -> mode unchanged.
- In EDIT with cursor 0, `switches=11110000` -> `options0=1111`, `en=0000`, `options1..3` unchanged, `leds[7:4]=1111`.
- EDIT mode, compiled with `CONTROL_BLINK_EN`: with cursor=2, `leds[3:0]` alternates `0100`/`0000` every 4 cycles. Compiled without it: `leds[3:0]` is steady `0100`.
